// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: opcode/func codes, FSM
// state encoding, operation kind, and a small decode helper.
package muldiv_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;

  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MTLO  = 6'b010011;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FIXUP = 2'b10
  } state_t;

  typedef enum logic {
    KIND_MUL = 1'b0,
    KIND_DIV = 1'b1
  } kind_t;

  typedef struct packed {
    kind_t kind;
    logic  sgn;
  } op_sel_t;

  // Within the MULT..DIVU group, bit 1 separates divide from multiply and bit 0 marks unsigned.
  function automatic op_sel_t decode_muldiv(input logic [5:0] func);
    op_sel_t sel;
    sel.kind = func[1] ? KIND_DIV : KIND_MUL;
    sel.sgn  = ~func[0];
    return sel;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// ID/EX-side handshake bundle between the pipeline and the multiply/divide sequencer.
interface muldiv_if #(parameter int DATA_W = 32);
  logic              id_valid;
  logic [0:5]        id_op;
  logic [0:5]        id_func;
  logic [DATA_W-1:0] id_rs_val;
  logic [DATA_W-1:0] id_rt_val;
  logic              ex_flush;
  logic              stall_o;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output id_valid, id_op, id_func, id_rs_val, id_rt_val, ex_flush,
    input  stall_o, busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  id_valid, id_op, id_func, id_rs_val, id_rt_val, ex_flush,
    output stall_o, busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// Shared iterative datapath: one shift-add (multiply) or restoring-subtract (divide)
// step per cycle on the {acc, q} register pair, operating on unsigned magnitudes.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  kind_t             kind,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] opnd;
  kind_t             kind_q;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   sub_rem;
  logic [DATA_W:0]   sub_diff;

  always_comb begin
    add_sum  = {1'b0, acc} + (q[0] ? {1'b0, opnd} : '0);
    sub_rem  = {acc, q[DATA_W-1]};
    sub_diff = sub_rem - {1'b0, opnd};
  end

  // Multiply: opnd = multiplicand, q = multiplier. Divide: opnd = divisor, q = dividend.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      q      <= '0;
      opnd   <= '0;
      kind_q <= KIND_MUL;
    end else if (load) begin
      acc    <= '0;
      kind_q <= kind;
      if (kind == KIND_MUL) begin
        opnd <= src_a;
        q    <= src_b;
      end else begin
        opnd <= src_b;
        q    <= src_a;
      end
    end else if (step) begin
      if (kind_q == KIND_MUL) begin
        acc <= add_sum[DATA_W:1];
        q   <= {add_sum[0], q[DATA_W-1:1]};
      end else if (!sub_diff[DATA_W]) begin
        acc <= sub_diff[DATA_W-1:0];
        q   <= {q[DATA_W-2:0], 1'b1};
      end else begin
        acc <= sub_rem[DATA_W-1:0];
        q   <= {q[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner and multi-cycle MULT/MULTU/DIV/DIVU sequencer; stalls ID while busy.
//   state   | meaning
//   S_IDLE  | no operation in flight; accepts muldiv, MTHI/MTLO writes
//   S_RUN   | DATA_W iteration steps on the shared core
//   S_FIXUP | sign correction and HI/LO write, then back to IDLE
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;
  logic              busy_r;
  logic              done_r;
  kind_t             kind_r;
  logic              neg_res_r;
  logic              neg_rem_r;
  logic              div_zero_r;

  logic              is_rtype;
  logic              is_muldiv;
  logic              is_mf;
  logic              is_mt;
  logic              accept;
  logic              mt_wr;
  op_sel_t           op;
  logic              rs_neg;
  logic              rt_neg;
  logic [DATA_W-1:0] rs_mag;
  logic [DATA_W-1:0] rt_mag;
  logic [DATA_W-1:0] core_acc;
  logic [DATA_W-1:0] core_q;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;

  always_comb begin
    is_rtype  = (bus.id_op == OP_RTYPE);
    is_muldiv = is_rtype & ((bus.id_func == FUNC_MULT) | (bus.id_func == FUNC_MULTU) |
                            (bus.id_func == FUNC_DIV)  | (bus.id_func == FUNC_DIVU));
    is_mf     = is_rtype & ((bus.id_func == FUNC_MFHI) | (bus.id_func == FUNC_MFLO));
    is_mt     = is_rtype & ((bus.id_func == FUNC_MTHI) | (bus.id_func == FUNC_MTLO));
    op        = decode_muldiv(bus.id_func);
    rs_neg    = op.sgn & bus.id_rs_val[DATA_W-1];
    rt_neg    = op.sgn & bus.id_rt_val[DATA_W-1];
    rs_mag    = rs_neg ? (~bus.id_rs_val + 1'b1) : bus.id_rs_val;
    rt_mag    = rt_neg ? (~bus.id_rt_val + 1'b1) : bus.id_rt_val;
    accept    = bus.id_valid & is_muldiv & (state == S_IDLE) & ~bus.ex_flush;
    mt_wr     = bus.id_valid & is_mt & (state == S_IDLE) & ~bus.ex_flush;
  end

  assign bus.stall_o = bus.id_valid & (is_muldiv | is_mf | is_mt) &
                       (state != S_IDLE) & ~bus.ex_flush;
  assign bus.busy_o  = busy_r;
  assign bus.done_o  = done_r;
  assign bus.hi_o    = hi_r;
  assign bus.lo_o    = lo_r;

  muldiv_iter_core #(.DATA_W(DATA_W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (state == S_RUN),
    .kind  (op.kind),
    .src_a (rs_mag),
    .src_b (rt_mag),
    .acc   (core_acc),
    .q     (core_q)
  );

  // Divide by zero forces an all-ones quotient regardless of sign; the remainder path
  // already reproduces rs because the core passes the dividend magnitude through.
  always_comb begin
    prod_fix = neg_res_r ? (~{core_acc, core_q} + 1'b1) : {core_acc, core_q};
    quo_fix  = div_zero_r ? '1 : (neg_res_r ? (~core_q + 1'b1) : core_q);
    rem_fix  = neg_rem_r ? (~core_acc + 1'b1) : core_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      kind_r     <= KIND_MUL;
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.ex_flush) begin
        state  <= S_IDLE;
        cnt    <= '0;
        busy_r <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              state      <= S_RUN;
              busy_r     <= 1'b1;
              cnt        <= '0;
              kind_r     <= op.kind;
              neg_res_r  <= rs_neg ^ rt_neg;
              neg_rem_r  <= rs_neg;
              div_zero_r <= (bus.id_rt_val == '0);
            end else if (mt_wr) begin
              if (bus.id_func == FUNC_MTHI) hi_r <= bus.id_rs_val;
              else                          lo_r <= bus.id_rs_val;
            end
          end
          S_RUN: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) state <= S_FIXUP;
          end
          S_FIXUP: begin
            if (kind_r == KIND_MUL) begin
              hi_r <= prod_fix[2*DATA_W-1:DATA_W];
              lo_r <= prod_fix[DATA_W-1:0];
            end else begin
              hi_r <= rem_fix;
              lo_r <= quo_fix;
            end
            state  <= S_IDLE;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
          default: begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus randomized
// operations checked against an arithmetic reference model of HI/LO.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if #(.DATA_W(W)) bus ();

  muldiv_sequencer #(.DATA_W(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_op(input logic [5:0] func, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [W-1:0] hi,
                                 output logic [W-1:0] lo);
    longint    sp;
    logic [63:0] up;
    hi = '0;
    lo = '0;
    case (func)
      FUNC_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {hi, lo} = sp;
      end
      FUNC_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        {hi, lo} = up;
      end
      FUNC_DIV: begin
        if (b == 0) begin
          hi = a; lo = '1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = '0; lo = a;
        end else begin
          lo = $signed(a) / $signed(b);
          hi = $signed(a) % $signed(b);
        end
      end
      default: begin
        if (b == 0) begin
          hi = a; lo = '1;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      4:       return 32'($urandom_range(1, 300));
      default: return 32'($urandom());
    endcase
  endfunction

  task automatic set_idle();
    bus.id_valid  = 1'b0;
    bus.id_op     = '0;
    bus.id_func   = '0;
    bus.id_rs_val = '0;
    bus.id_rt_val = '0;
    bus.ex_flush  = 1'b0;
  endtask

  task automatic drive(input logic [5:0] func, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.id_valid  = 1'b1;
    bus.id_op     = OP_RTYPE;
    bus.id_func   = func;
    bus.id_rs_val = a;
    bus.id_rt_val = b;
  endtask

  // Called just after the accepting edge; returns edges until done_o is seen,
  // plus the number of sampled cycles with busy_o and stall_o high.
  task automatic wait_done(input string tag, output int edges, output int n_busy,
                           output int n_stall);
    edges = -1; n_busy = 0; n_stall = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bus.done_o) begin
        edges = k - 1;
        break;
      end
      if (bus.busy_o)  n_busy++;
      if (bus.stall_o) n_stall++;
    end
    if (edges < 0) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [5:0] func, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int e, nb, ns;
    drive(func, a, b);
    @(posedge clk);
    #1 set_idle();
    wait_done(tag, e, nb, ns);
    ref_op(func, a, b, m_hi, m_lo);
    chk({tag, "_hi"}, 64'(bus.hi_o), 64'(m_hi));
    chk({tag, "_lo"}, 64'(bus.lo_o), 64'(m_lo));
    chk({tag, "_edges"}, 64'(e), 64'(LAT));
    chk({tag, "_busy_cycles"}, 64'(nb), 64'(LAT));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(bus.done_o), 64'd0);
  endtask

  task automatic write_mt(input string tag, input logic [5:0] func, input logic [W-1:0] v);
    drive(func, v, 32'hDEAD_BEEF);
    @(posedge clk);
    #1 set_idle();
    if (func == FUNC_MTHI) m_hi = v; else m_lo = v;
    @(negedge clk);
    chk({tag, "_hi"}, 64'(bus.hi_o), 64'(m_hi));
    chk({tag, "_lo"}, 64'(bus.lo_o), 64'(m_lo));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, nb, ns;
    logic [W-1:0] a, b, a2, b2, exp_hi, exp_lo;
    logic [5:0] fn;
    bit saw_done;

    set_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hi", 64'(bus.hi_o), 64'd0);
    chk("rst_lo", 64'(bus.lo_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);

    run_op("multu_7x6", FUNC_MULTU, 32'd7, 32'd6);
    chk("multu_7x6_lo_const", 64'(bus.lo_o), 64'd42);
    run_op("mult_m3x5", FUNC_MULT, -32'sd3, 32'd5);
    chk("mult_m3x5_hi_const", 64'(bus.hi_o), 64'hFFFF_FFFF);
    chk("mult_m3x5_lo_const", 64'(bus.lo_o), 64'hFFFF_FFF1);
    run_op("div_m7d2", FUNC_DIV, -32'sd7, 32'd2);
    chk("div_m7d2_lo_const", 64'(bus.lo_o), 64'hFFFF_FFFD);
    chk("div_m7d2_hi_const", 64'(bus.hi_o), 64'hFFFF_FFFF);
    run_op("divu_100d0", FUNC_DIVU, 32'd100, 32'd0);
    chk("divu_100d0_hi_const", 64'(bus.hi_o), 64'd100);
    chk("divu_100d0_lo_const", 64'(bus.lo_o), 64'hFFFF_FFFF);
    run_op("div_ovf", FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo_const", 64'(bus.lo_o), 64'h8000_0000);
    run_op("div_m5d0", FUNC_DIV, -32'sd5, 32'd0);

    // MFHI right behind a MULT must stall until the result lands
    a = 32'h1234_5678; b = 32'hFEDC_BA98;
    drive(FUNC_MULT, a, b);
    @(posedge clk);
    #1 drive(FUNC_MFHI, 32'h0, 32'h0);
    wait_done("mfhi", e, nb, ns);
    ref_op(FUNC_MULT, a, b, m_hi, m_lo);
    chk("mfhi_stall_cycles", 64'(ns), 64'(LAT));
    chk("mfhi_stall_at_done", 64'(bus.stall_o), 64'd0);
    chk("mfhi_value", 64'(bus.hi_o), 64'(m_hi));
    @(posedge clk);
    #1 set_idle();

    // back-to-back MULTU: second is held, then accepted on the done_o cycle
    a = 32'd1000; b = 32'd3000; a2 = 32'hFFFF_FFFF; b2 = 32'hFFFF_FFFF;
    drive(FUNC_MULTU, a, b);
    @(posedge clk);
    #1 drive(FUNC_MULTU, a2, b2);
    wait_done("b2b_first", e, nb, ns);
    ref_op(FUNC_MULTU, a, b, m_hi, m_lo);
    chk("b2b_stall_cycles", 64'(ns), 64'(LAT));
    chk("b2b_first_lo", 64'(bus.lo_o), 64'(m_lo));
    chk("b2b_first_hi", 64'(bus.hi_o), 64'(m_hi));
    @(posedge clk);
    #1 set_idle();
    wait_done("b2b_second", e, nb, ns);
    ref_op(FUNC_MULTU, a2, b2, m_hi, m_lo);
    chk("b2b_second_edges", 64'(e), 64'(LAT));
    chk("b2b_second_hi", 64'(bus.hi_o), 64'(m_hi));
    chk("b2b_second_lo", 64'(bus.lo_o), 64'(m_lo));
    @(negedge clk);

    // flush mid-RUN leaves MTHI/MTLO values intact and produces no done_o
    write_mt("mthi", FUNC_MTHI, 32'hA5);
    write_mt("mtlo", FUNC_MTLO, 32'h5A);
    drive(FUNC_MULT, 32'd123, 32'd456);
    @(posedge clk);
    #1 set_idle();
    repeat (9) @(posedge clk);
    #1 bus.ex_flush = 1'b1;
    @(posedge clk);
    #1 bus.ex_flush = 1'b0;
    @(negedge clk);
    chk("flush_run_busy", 64'(bus.busy_o), 64'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done_o) saw_done = 1'b1;
    end
    chk("flush_run_no_done", 64'(saw_done), 64'd0);
    chk("flush_run_hi", 64'(bus.hi_o), 64'hA5);
    chk("flush_run_lo", 64'(bus.lo_o), 64'h5A);

    // flush coinciding with an accept wins
    drive(FUNC_DIVU, 32'd9, 32'd3);
    bus.ex_flush = 1'b1;
    @(posedge clk);
    #1 set_idle();
    @(negedge clk);
    chk("flush_accept_busy", 64'(bus.busy_o), 64'd0);

    // flush during FIXUP suppresses the HI/LO write
    drive(FUNC_DIVU, 32'd50, 32'd7);
    @(posedge clk);
    #1 set_idle();
    repeat (W) @(posedge clk);
    #1 bus.ex_flush = 1'b1;
    chk("fixup_busy_before_flush", 64'(bus.busy_o), 64'd1);
    @(posedge clk);
    #1 bus.ex_flush = 1'b0;
    @(negedge clk);
    chk("flush_fixup_done", 64'(bus.done_o), 64'd0);
    chk("flush_fixup_busy", 64'(bus.busy_o), 64'd0);
    chk("flush_fixup_hi", 64'(bus.hi_o), 64'hA5);
    chk("flush_fixup_lo", 64'(bus.lo_o), 64'h5A);

    // reset mid-RUN discards everything
    drive(FUNC_MULTU, 32'd77, 32'd88);
    @(posedge clk);
    #1 set_idle();
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    chk("rst_run_hi", 64'(bus.hi_o), 64'd0);
    chk("rst_run_lo", 64'(bus.lo_o), 64'd0);
    chk("rst_run_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_run_done", 64'(bus.done_o), 64'd0);
    run_op("multu_3x3", FUNC_MULTU, 32'd3, 32'd3);
    chk("multu_3x3_lo_const", 64'(bus.lo_o), 64'd9);

    // randomized mix of muldiv and MTHI/MTLO against the model
    for (int i = 0; i < 40; i++) begin
      a = pick_val();
      b = pick_val();
      case ($urandom_range(0, 5))
        0: fn = FUNC_MULT;
        1: fn = FUNC_MULTU;
        2: fn = FUNC_DIV;
        3: fn = FUNC_DIVU;
        4: fn = FUNC_MTHI;
        default: fn = FUNC_MTLO;
      endcase
      if (fn == FUNC_MTHI || fn == FUNC_MTLO) begin
        write_mt($sformatf("rnd%0d_mt", i), fn, a);
      end else begin
        run_op($sformatf("rnd%0d_f%0h_%0h_%0h", i, fn, a, b), fn, a, b);
      end
    end

    // a non-muldiv R-type never stalls or touches HI/LO, even while busy
    exp_hi = m_hi; exp_lo = m_lo;
    drive(FUNC_MULTU, 32'd5, 32'd5);
    @(posedge clk);
    #1 drive(6'b100001, 32'h1111, 32'h2222);
    @(negedge clk);
    chk("nonmuldiv_stall", 64'(bus.stall_o), 64'd0);
    chk("nonmuldiv_hi_keep", 64'(bus.hi_o), 64'(exp_hi));
    set_idle();
    wait_done("nonmuldiv_tail", e, nb, ns);
    chk("nonmuldiv_tail_lo", 64'(bus.lo_o), 64'd25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
